set_mode_ctrl_57: RTL and testbench
===================================

Name: set_mode_ctrl_57

Overview:
- Front-panel key front end for the clock's time-setting path.
- Synchronises and debounces three raw push-buttons (mode, add, sub) and runs the setting-mode state machine.
- Drives the per-field set enables (hour/min/sec/week) and clean single-cycle add/sub pulses into the field controllers, including week_ctrl_57 (week_e_57, key_add_57, key_sub_57).
- Falls back to run mode automatically after an inactivity timeout.

Parameters:
- DEB_CYCLES, 1000000: consecutive clk cycles a synchronised key level must differ from its debounced level before the debounced level updates (20 ms at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 500000000: cycles without an accepted key press in any SET state before returning to RUN (10 s at 50 MHz); minimum 2.

Ports:
- clk_50m_57  in  1  50 MHz system clock
- rst_57  in  1  reset; one clock domain, asynchronous, active-high
- key_mode_raw_57  in  1  raw mode button, active-high, asynchronous to clk
- key_add_raw_57  in  1  raw add button, active-high, asynchronous
- key_sub_raw_57  in  1  raw sub button, active-high, asynchronous
- hour_e_57  out  1  high while state is SET_HOUR
- min_e_57  out  1  high while state is SET_MIN
- sec_e_57  out  1  high while state is SET_SEC
- week_e_57  out  1  high while state is SET_WEEK
- key_add_57  out  1  one-cycle add pulse
- key_sub_57  out  1  one-cycle sub pulse
- mode_o_57  out  3  current state code, for display blinking

Behaviour:
- Reset (asynchronous assert, synchronous release): all sync flops, debounced levels and counters go to 0. State = RUN. All outputs 0, mode_o_57 = 0.
- Synchroniser: each raw key passes through a 2-flop synchroniser (s1, s2).
- Debounce, per key:
  - Counter clears whenever s2 == debounced level; otherwise it increments.
  - At the edge where the counter == DEB_CYCLES-1 and s2 still differs, the debounced level <= s2 and the counter clears.
  - Counter width is $clog2(DEB_CYCLES); it never wraps.
- Press detect: press = debounced rises 0->1, registered.
  - Press strobe is high for exactly one cycle, the cycle after the debounced level rises.
  - Release generates nothing.
  - Latency from the first raw high sampled to the strobe = 2 + DEB_CYCLES + 1 cycles.
  - A key held through reset release is reported as a press after the debounce time.
- State encoding: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, SET_WEEK=4. Codes 5-7 are illegal and recover to RUN on the next cycle.
- Transitions on an accepted mode press: RUN->SET_HOUR->SET_MIN->SET_SEC->SET_WEEK->RUN.
- Enables: decoded from the registered state; exactly one enable is high in SET states, none in RUN.
- Add/sub output:
  - key_add_57 / key_sub_57 are registered and assert one cycle after the add/sub press strobe, only if the state is not RUN.
  - In RUN, add/sub presses are discarded.
- Simultaneous strobes in the same cycle:
  - mode + add/sub: mode advances; add/sub is dropped.
  - add + sub: add wins; sub is dropped.
  - A pulse never coincides with the state-change cycle for the same press.
- Timeout:
  - Counter runs only in SET states and clears in RUN and on any accepted press (mode, add, sub).
  - On reaching TIMEOUT_CYCLES-1 the state -> RUN and the counter clears.
  - If the timeout and a mode press land in the same cycle, the mode press wins.
- Reset mid-operation: any state returns to RUN immediately, and any pulse in flight is dropped.

Test Plan (bench uses DEB_CYCLES=4, TIMEOUT_CYCLES=64):
- Reset: assert rst_57 mid-cycle in SET_MIN -> all outputs 0 asynchronously, mode_o_57=0; a mode press after release -> SET_HOUR.
- Bounce rejection:
  - add raw toggling with high periods of 3 cycles -> no key_add_57 pulse.
  - Held high 10 cycles in SET_WEEK -> exactly one key_add_57 pulse, 8 cycles after the first raw-high sample (2+4+1 to strobe, +1 output register).
- Mode cycle: 5 clean mode presses -> mode_o_57 goes 1,2,3,4,0; week_e_57 is high only at 4.
- RUN gating and priority:
  - add press in RUN -> no pulse.
  - add+sub raw rising together in SET_SEC -> single key_add_57, no key_sub_57.
  - mode+add together in SET_SEC -> SET_WEEK, no pulse.
- Timeout:
  - In SET_HOUR, no keys for 64 cycles -> RUN.
  - A sub press at cycle 50 restarts the count, so RUN is entered 64 cycles after that press.
- Held key: hold add 200 cycles in SET_MIN -> one pulse only; release produces no pulse.

Source files
------------

// File: rtl/set_mode_ctrl_57_if.sv
// set_mode_ctrl_57_if: front-panel key bundle between the raw buttons and the setting-mode controller.
//   key_mode_raw_57/key_add_raw_57/key_sub_raw_57 : raw active-high buttons (asynchronous to clk)
//   hour_e_57/min_e_57/sec_e_57/week_e_57        : per-field set enables
//   key_add_57/key_sub_57                         : single-cycle add/sub pulses
//   mode_o_57                                     : current state code
interface set_mode_ctrl_57_if;
    logic       key_mode_raw_57, key_add_raw_57, key_sub_raw_57;
    logic       hour_e_57, min_e_57, sec_e_57, week_e_57;
    logic       key_add_57, key_sub_57;
    logic [2:0] mode_o_57;
    modport master (
        output key_mode_raw_57, key_add_raw_57, key_sub_raw_57,
        input  hour_e_57, min_e_57, sec_e_57, week_e_57, key_add_57, key_sub_57, mode_o_57
    );
    modport slave (
        input  key_mode_raw_57, key_add_raw_57, key_sub_raw_57,
        output hour_e_57, min_e_57, sec_e_57, week_e_57, key_add_57, key_sub_57, mode_o_57
    );
endinterface

// File: rtl/set_mode_ctrl_57.sv
// set_mode_ctrl_57: key synchroniser/debouncer and time-setting mode FSM with inactivity timeout.
//   clk_50m_57 : system clock
//   rst_57     : asynchronous active-high reset
//   bus        : set_mode_ctrl_57_if.slave (raw keys in; enables, add/sub pulses, mode code out)
module set_mode_ctrl_57 #(
    parameter int DEB_CYCLES     = 1000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input logic             clk_50m_57,
    input logic             rst_57,
    set_mode_ctrl_57_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {RUN = 3'd0, SET_HOUR = 3'd1, SET_MIN = 3'd2, SET_SEC = 3'd3, SET_WEEK = 3'd4} state_t;
    // key vectors: bit 0 = mode, bit 1 = add, bit 2 = sub
    logic [2:0] raw, s1, s2, deb, deb_d, stb;
    logic [TW-1:0] to_cnt;
    state_t state, state_nx;
    logic in_set, act, to_hit, add_nx, sub_nx, add_q, sub_q;
    assign raw = {bus.key_sub_raw_57, bus.key_add_raw_57, bus.key_mode_raw_57};
    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            s1    <= '0;
            s2    <= '0;
            deb_d <= '0;
            stb   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            stb   <= deb & ~deb_d;
        end
    end
    // debounced level follows s2 only after DEB_CYCLES consecutive disagreeing samples
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          lvl;
        always_ff @(posedge clk_50m_57 or posedge rst_57) begin
            if (rst_57) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (s2[i] == lvl) cnt <= '0;
            else if (cnt == DW'(DEB_CYCLES - 1)) begin
                lvl <= s2[i];
                cnt <= '0;
            end else cnt <= cnt + DW'(1);
        end
        assign deb[i] = lvl;
    end
    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            state  <= RUN;
            to_cnt <= '0;
            add_q  <= 1'b0;
            sub_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            to_cnt <= (!in_set || act || to_hit) ? '0 : to_cnt + TW'(1);
            add_q  <= add_nx;
            sub_q  <= sub_nx;
        end
    end
    // a mode strobe outranks add/sub and the timeout; add outranks sub
    always_comb begin
        in_set = state != RUN && state <= SET_WEEK;
        act    = |stb;
        to_hit = in_set && !act && to_cnt == TW'(TIMEOUT_CYCLES - 1);
        add_nx = in_set && stb[1] && !stb[0];
        sub_nx = in_set && stb[2] && !stb[1] && !stb[0];
        state_nx = RUN;
        case (state)
            RUN:      state_nx = stb[0] ? SET_HOUR : RUN;
            SET_HOUR: state_nx = stb[0] ? SET_MIN  : to_hit ? RUN : SET_HOUR;
            SET_MIN:  state_nx = stb[0] ? SET_SEC  : to_hit ? RUN : SET_MIN;
            SET_SEC:  state_nx = stb[0] ? SET_WEEK : to_hit ? RUN : SET_SEC;
            SET_WEEK: state_nx = stb[0] ? RUN      : to_hit ? RUN : SET_WEEK;
            default:  state_nx = RUN;
        endcase
    end
    assign bus.hour_e_57  = state == SET_HOUR;
    assign bus.min_e_57   = state == SET_MIN;
    assign bus.sec_e_57   = state == SET_SEC;
    assign bus.week_e_57  = state == SET_WEEK;
    assign bus.key_add_57 = add_q;
    assign bus.key_sub_57 = sub_q;
    assign bus.mode_o_57  = state;
endmodule

// File: tb/tb_set_mode_ctrl_57.sv
// tb_set_mode_ctrl_57: vector table, directed corner sequences and random keys against a cycle model.
module tb_set_mode_ctrl_57;
    localparam int DEB = 4;
    localparam int TO  = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    set_mode_ctrl_57_if bus();
    set_mode_ctrl_57 #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50m_57(clk),
        .rst_57(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    int pass_cnt = 0;
    int total_cnt = 0;
    int n_add, n_sub;
    // keys: bit 0 = mode, bit 1 = add, bit 2 = sub; en: {hour, min, sec, week}
    typedef struct {
        logic [2:0] keys;
        int         hold;
        int         settle;
        logic [2:0] mode;
        logic [3:0] en;
        int         adds;
        int         subs;
    } vec_t;
    vec_t tv [12];
    // reference model: a key's clean level flips once the last DEB synchronised samples all disagree with it
    logic [2:0] m_s1, m_s2, m_deb, m_rose, m_stb;
    logic [DEB-1:0] m_hist [3];
    int m_st, m_last, m_cyc;
    logic m_add, m_sub;
    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_rose = '0; m_stb = '0;
        for (int k = 0; k < 3; k++) m_hist[k] = '0;
        m_st = 0; m_last = 0; m_cyc = 0; m_add = 1'b0; m_sub = 1'b0;
    endtask
    task automatic model_edge();
        logic [2:0] raw, stb, up;
        int st0;
        if (rst) begin
            model_reset();
            return;
        end
        raw = {bus.key_sub_raw_57, bus.key_add_raw_57, bus.key_mode_raw_57};
        m_cyc++;
        stb = m_stb;
        st0 = m_st;
        m_add = stb[1] && !stb[0] && st0 != 0;
        m_sub = stb[2] && !stb[1] && !stb[0] && st0 != 0;
        if (stb[0]) m_st = (st0 + 1) % 5;
        else if (st0 != 0 && stb == 3'b000 && m_cyc - m_last == TO) m_st = 0;
        if (st0 == 0 || stb != 3'b000) m_last = m_cyc;
        up = '0;
        for (int k = 0; k < 3; k++) begin
            m_hist[k] = {m_hist[k][DEB-2:0], m_s2[k]};
            if (m_hist[k] == {DEB{~m_deb[k]}}) begin
                up[k] = ~m_deb[k];
                m_deb[k] = ~m_deb[k];
            end
        end
        m_stb = m_rose;
        m_rose = up;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask
    task automatic check_model(input string nm);
        logic [8:0] got, want;
        got  = {bus.mode_o_57, bus.hour_e_57, bus.min_e_57, bus.sec_e_57, bus.week_e_57, bus.key_add_57, bus.key_sub_57};
        want = {3'(m_st), m_st == 1, m_st == 2, m_st == 3, m_st == 4, m_add, m_sub};
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s @%0t: {mode,h,m,s,w,add,sub} got %b want %b", nm, $time, got, want);
    endtask
    task automatic expect_int(input string nm, input int got, input int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask
    task automatic set_raw(input logic [2:0] k);
        bus.key_mode_raw_57 = k[0];
        bus.key_add_raw_57  = k[1];
        bus.key_sub_raw_57  = k[2];
    endtask
    task automatic step(input string nm);
        model_edge();
        @(posedge clk);
        #1;
        check_model(nm);
        if (bus.key_add_57) n_add++;
        if (bus.key_sub_57) n_sub++;
    endtask
    task automatic press(input logic [2:0] k);
        set_raw(k);
        repeat (6) step("press");
        set_raw(3'b000);
        repeat (10) step("press");
    endtask
    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model(nm);
        expect_int({nm, "_mode"}, int'(bus.mode_o_57), 0);
        step(nm);
        step(nm);
        rst = 1'b0;
    endtask
    task automatic enter_set_hour(input string nm);
        bit found = 0;
        set_raw(3'b001);
        for (int i = 0; i < 20 && !found; i++) begin
            step(nm);
            if (i == 5) set_raw(3'b000);
            if (bus.mode_o_57 == 3'd1) found = 1;
        end
        set_raw(3'b000);
        expect_int({nm, "_entered"}, int'(found), 1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int first;
        bit found;
        tv[0]  = '{3'b010,   6, 10, 3'd0, 4'b0000, 0, 0};
        tv[1]  = '{3'b001,   6, 10, 3'd1, 4'b1000, 0, 0};
        tv[2]  = '{3'b001,   6, 10, 3'd2, 4'b0100, 0, 0};
        tv[3]  = '{3'b001,   6, 10, 3'd3, 4'b0010, 0, 0};
        tv[4]  = '{3'b110,   6, 10, 3'd3, 4'b0010, 1, 0};
        tv[5]  = '{3'b011,   6, 10, 3'd4, 4'b0001, 0, 0};
        tv[6]  = '{3'b001,   6, 10, 3'd0, 4'b0000, 0, 0};
        tv[7]  = '{3'b001,   6, 10, 3'd1, 4'b1000, 0, 0};
        tv[8]  = '{3'b001,   6, 10, 3'd2, 4'b0100, 0, 0};
        tv[9]  = '{3'b010, 200, 10, 3'd0, 4'b0000, 1, 0};
        tv[10] = '{3'b001,   6, 10, 3'd1, 4'b1000, 0, 0};
        tv[11] = '{3'b100,   6, 10, 3'd1, 4'b1000, 0, 1};
        set_raw(3'b000);
        model_reset();
        step("reset");
        step("reset");
        expect_int("reset_mode", int'(bus.mode_o_57), 0);
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            n_add = 0;
            n_sub = 0;
            set_raw(tv[t].keys);
            repeat (tv[t].hold) step("vec");
            set_raw(3'b000);
            repeat (tv[t].settle) step("vec");
            expect_int($sformatf("vec%0d_mode", t), int'(bus.mode_o_57), int'(tv[t].mode));
            expect_int($sformatf("vec%0d_en", t), int'({bus.hour_e_57, bus.min_e_57, bus.sec_e_57, bus.week_e_57}), int'(tv[t].en));
            expect_int($sformatf("vec%0d_adds", t), n_add, tv[t].adds);
            expect_int($sformatf("vec%0d_subs", t), n_sub, tv[t].subs);
        end
        press(3'b001);
        expect_int("pre_rst_min", int'(bus.mode_o_57), 2);
        async_reset("rst_mid");
        press(3'b001);
        expect_int("post_rst_hour", int'(bus.mode_o_57), 1);
        repeat (3) press(3'b001);
        expect_int("week_state", int'(bus.week_e_57), 1);
        n_add = 0;
        repeat (5) begin
            set_raw(3'b010);
            repeat (3) step("bounce");
            set_raw(3'b000);
            repeat (3) step("bounce");
        end
        expect_int("bounce_nopulse", n_add, 0);
        n_add = 0;
        first = 0;
        set_raw(3'b010);
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) set_raw(3'b000);
            step("latency");
            if (bus.key_add_57 && first == 0) first = i;
        end
        expect_int("latency_edge", first, 8);
        expect_int("latency_count", n_add, 1);
        press(3'b001);
        expect_int("back_to_run", int'(bus.mode_o_57), 0);
        enter_set_hour("to1");
        repeat (TO - 1) step("to1_wait");
        expect_int("to1_still_set", int'(bus.mode_o_57), 1);
        step("to1_wait");
        expect_int("to1_run", int'(bus.mode_o_57), 0);
        enter_set_hour("to2");
        repeat (50) step("to2_wait");
        set_raw(3'b100);
        found = 0;
        for (int j = 1; j <= 20 && !found; j++) begin
            if (j == 6) set_raw(3'b000);
            step("to2_sub");
            if (bus.key_sub_57) found = 1;
        end
        set_raw(3'b000);
        expect_int("to2_sub_pulse", int'(found), 1);
        repeat (TO - 1) step("to2_wait");
        expect_int("to2_still_set", int'(bus.mode_o_57), 1);
        step("to2_wait");
        expect_int("to2_run", int'(bus.mode_o_57), 0);
        for (int r = 0; r < 300; r++) begin
            set_raw($urandom_range(0, 1) ? 3'b000 : 3'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 12)) step("rand");
            if ($urandom_range(0, 39) == 0) async_reset("rand_rst");
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
